// File: rtl/alu_pkg.sv
// Shared definitions for the ALU round-robin scheduler.
// Opcode encodings and scheduler FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1,
// returning a one-hot grant and its index.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      logic [IW-1:0] j;
      j = IW'((int'(ptr) + i) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external ALU among requesters,
// with registered issue, result capture and a tagged response port.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int OPW     = 3,
  parameter int CNTW    = 16,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OPW-1:0]   req_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [OPW-1:0]           alu_op,
  input  logic [WIDTH-1:0]         alu_y,
  input  logic                     alu_c,
  input  logic                     alu_z,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
  output logic [WIDTH-1:0]         rsp_y,
  output logic                     rsp_c,
  output logic                     rsp_z,
  output logic                     busy,
  output logic [CNTW-1:0]          ops_done
);

  state_t              state_q;
  state_t              state_d;
  logic [IW-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gidx;
  logic                any;
  logic                accept;
  logic                fire;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign accept = (state_q == S_IDLE) && any;
  assign fire   = (state_q == S_RESP) && rsp_valid && rsp_ready;
  assign busy   = (state_q != S_IDLE);

  // Ready is forced low while reset is held, even though state reads IDLE.
  assign req_ready = (state_q == S_IDLE && rst_n) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (any) state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= IW'(NUM_REQ - 1);
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_c     <= 1'b0;
      rsp_z     <= 1'b0;
      rsp_valid <= 1'b0;
      ops_done  <= '0;
    end else begin
      if (accept) begin
        alu_a  <= req_a[gidx*WIDTH +: WIDTH];
        alu_b  <= req_b[gidx*WIDTH +: WIDTH];
        alu_op <= req_op[gidx*OPW +: OPW];
        rsp_id <= gidx;
      end
      if (state_q == S_EXEC) begin
        rsp_y     <= alu_y;
        rsp_c     <= alu_c;
        rsp_z     <= alu_z;
        rsp_valid <= 1'b1;
      end
      if (fire) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= rsp_id;
        ops_done  <= ops_done + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: directed scenarios plus random
// traffic checked against a transaction-level model.
module tb_alu_rr_scheduler;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int OPW  = 3;
  localparam int CNTW = 16;
  localparam int IW   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*OPW-1:0] req_op;
  logic [W-1:0]     alu_a, alu_b, alu_y;
  logic [OPW-1:0]   alu_op;
  logic             alu_c, alu_z;
  logic             rsp_valid, rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [W-1:0]     rsp_y;
  logic             rsp_c, rsp_z, busy;
  logic [CNTW-1:0]  ops_done;

  logic [N-1:0]   rv;
  logic [W-1:0]   ra [N];
  logic [W-1:0]   rb [N];
  logic [OPW-1:0] rop [N];

  int checks = 0;
  int errs   = 0;

  int           phase;
  int           last;
  int           eid;
  int           ops;
  logic [W-1:0] ea, eb;
  logic [2:0]   eop;
  logic [W+1:0] eres;
  int           gq [$];

  always #5 clk = ~clk;

  alu_rr_scheduler #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .OPW     (OPW),
    .CNTW    (CNTW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .alu_c     (alu_c),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_c     (rsp_c),
    .rsp_z     (rsp_z),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  // Returns {z, c, y}.
  function automatic logic [W+1:0] alu_f(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [2:0]   op);
    logic [W:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {a, 1'b0};
      default: r = {a[0], 1'b0, a[W-1:1]};
    endcase
    return {(r[W-1:0] == '0), r};
  endfunction

  assign {alu_z, alu_c, alu_y} = alu_f(alu_a, alu_b, alu_op);

  always_comb begin
    req_valid = rv;
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]    = ra[i];
      req_b[i*W +: W]    = rb[i];
      req_op[i*OPW +: OPW] = rop[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Winner = valid requester with the smallest cyclic distance after last.
  function automatic int pick();
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      int d;
      d = (i - last - 1 + 2 * N) % N;
      if (rv[i] && d < bd) begin
        best = i;
        bd   = d;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    phase = 0;
    last  = N - 1;
    eid   = 0;
    ops   = 0;
    ea    = '0;
    eb    = '0;
    eop   = '0;
    eres  = '0;
  endtask

  // Called at a negedge with inputs already set; returns at next negedge.
  task automatic step();
    logic [N-1:0] er;
    int g;
    #1;
    er = '0;
    g  = -1;
    if (phase == 0) begin
      g = pick();
      if (g >= 0) er = N'(1) << g;
    end
    check("req_ready", 32'(req_ready), 32'(er));
    check("busy", 32'(busy), 32'(phase != 0));
    check("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
    check("alu_regs", 32'({alu_a, alu_b, alu_op}), 32'({ea, eb, eop}));
    check("ops_done", 32'(ops_done), 32'(ops % 65536));
    if (phase == 2) begin
      check("rsp_id", 32'(rsp_id), 32'(eid));
      check("rsp_zcy", 32'({rsp_z, rsp_c, rsp_y}), 32'(eres));
    end
    if (phase == 0 && g >= 0) begin
      ea   = ra[g];
      eb   = rb[g];
      eop  = rop[g];
      eres = alu_f(ra[g], rb[g], rop[g]);
      eid  = g;
      gq.push_back(g);
      phase = 1;
    end else if (phase == 1) begin
      phase = 2;
    end else if (phase == 2 && rsp_ready) begin
      ops++;
      last  = eid;
      phase = 0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) rv[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_ops", 32'(ops_done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op);
    ra[i]  = a;
    rb[i]  = b;
    rop[i] = op;
    rv[i]  = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rv        = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ra[i]  = '0;
      rb[i]  = '0;
      rop[i] = '0;
    end
    model_reset();
    @(negedge clk);
    rv[0] = 1'b1;
    do_reset();
    rv = '0;

    // Directed: ADD 5+3 on req0, then ADD F+1 on req1.
    set_req(0, 4'b0101, 4'b0011, 3'd0);
    repeat (2) step();
    check("t1_rsp", 32'({rsp_valid, rsp_id, rsp_c, rsp_z, rsp_y}),
          32'(9'b1_00_0_0_1000));
    step();
    set_req(1, 4'b1111, 4'b0001, 3'd0);
    repeat (2) step();
    check("t2_rsp", 32'({rsp_valid, rsp_id, rsp_c, rsp_z, rsp_y}),
          32'(9'b1_01_1_1_0000));
    step();
    check("t2_ops", 32'(ops_done), 32'd2);

    // All requesters valid from reset: order 0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, W'($urandom), W'($urandom), 3'($urandom));
    gq.delete();
    repeat (12) step();
    check("t3_cnt", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check("t3_order", 32'(gq[i]), 32'(i));

    // req0 and req2 always valid: ids alternate.
    gq.delete();
    for (int k = 0; k < 12; k++) begin
      rv[0] = 1'b1;
      rv[2] = 1'b1;
      step();
    end
    rv = '0;
    check("t4_cnt", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check("t4_order", 32'(gq[i]), (i % 2 == 0) ? 32'd0 : 32'd2);

    // Backpressure held for 5 cycles in RESP.
    set_req(1, 4'b1001, 4'b0100, 3'd1);
    rsp_ready = 1'b0;
    repeat (2) step();
    set_req(0, 4'b0011, 4'b0000, 3'd6);
    repeat (5) step();
    rsp_ready = 1'b1;
    step();
    check("t5_ops", 32'(ops_done), 32'(ops % 65536));
    repeat (3) step();

    // Reset during EXEC drops the op; req0 wins afterwards.
    set_req(3, 4'b0111, 4'b0001, 3'd0);
    step();
    check("t6_busy_pre", 32'(busy), 32'd1);
    rv = '0;
    do_reset();
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < N; i++)
      set_req(i, W'($urandom), W'($urandom), 3'($urandom));
    #1;
    check("t6_first", 32'(req_ready), 32'd1);
    repeat (12) step();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && ($urandom % 3 == 0))
          set_req(i, W'($urandom), W'($urandom), 3'($urandom));
      rsp_ready = ($urandom % 4 != 0);
      step();
    end
    rv = '0;
    rsp_ready = 1'b1;
    repeat (4) step();
    check("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule
